// File: rtl/decode_pkg.sv
// Shared types and constants for the decode stage.
// Optional feature macro: DECODE_BRANCH_EN (BEQ/BNE and JAL decode).
package decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_PASS_B
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED,
    TRAP
  } state_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_U,
    IMM_B,
    IMM_J
  } imm_type_t;

endpackage

// File: rtl/decode_stage_if.sv
// Upstream instruction handshake plus downstream decoded bundle.
// master drives the stage inputs, slave is the decode stage itself.
// Optional feature macro: DECODE_BRANCH_EN adds out_branch/out_jump.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  import decode_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_reg_write;
  logic            out_mem_read;
  logic            out_mem_write;
  logic            out_alu_src;
  alu_ctrl_t       out_alu_ctrl;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc;
`ifdef DECODE_BRANCH_EN
  logic            out_branch;
  logic            out_jump;
`endif

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_rs1, out_rs2, out_rd, out_reg_write,
           out_mem_read, out_mem_write, out_alu_src, out_alu_ctrl, out_imm, out_pc
`ifdef DECODE_BRANCH_EN
    , input out_branch, out_jump
`endif
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_rs1, out_rs2, out_rd, out_reg_write,
           out_mem_read, out_mem_write, out_alu_src, out_alu_ctrl, out_imm, out_pc
`ifdef DECODE_BRANCH_EN
    , output out_branch, out_jump
`endif
  );

endinterface

// File: rtl/decode_imm_gen.sv
// Combinational RV32 immediate extraction, sign-extended to XLEN.
module decode_imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_type_t       imm_type,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] imm32;

  // Select the 32-bit immediate format, then sign-extend from bit 31.
  always_comb begin
    imm32 = '0;
    case (imm_type)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm = XLEN'(imm32);
  end

endmodule

// File: rtl/decode_stage.sv
// RV32 decode stage: registered one-deep output bundle, ECALL halt,
// sticky illegal-instruction trap and saturating retired counter.
// Optional feature macro: DECODE_BRANCH_EN (BEQ/BNE and JAL decode).
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  decode_stage_if.slave    bus,
  output logic             finish,
  output logic             illegal,
  output logic [31:0]      illegal_instr,
  output logic [CNT_W-1:0] instr_count
);

  state_t          state, state_next;
  logic            accept;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            dec_legal, dec_ecall;
  logic            dec_reg_write, dec_mem_read, dec_mem_write, dec_alu_src;
  alu_ctrl_t       dec_alu_ctrl;
  imm_type_t       dec_imm_type;
  logic [XLEN-1:0] dec_imm;
`ifdef DECODE_BRANCH_EN
  logic            dec_branch, dec_jump;
`endif

  assign opcode = bus.in_instr[6:0];
  assign funct3 = bus.in_instr[14:12];
  assign funct7 = bus.in_instr[31:25];

  assign bus.in_ready = (state == RUN) && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  decode_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr    (bus.in_instr),
    .imm_type (dec_imm_type),
    .imm      (dec_imm)
  );

  // Classify the incoming word and derive its control strobes.
  always_comb begin
    dec_legal     = 1'b0;
    dec_ecall     = 1'b0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_alu_src   = 1'b0;
    dec_alu_ctrl  = ALU_ADD;
    dec_imm_type  = IMM_NONE;
`ifdef DECODE_BRANCH_EN
    dec_branch    = 1'b0;
    dec_jump      = 1'b0;
`endif
    case (opcode)
      OPC_LOAD: begin
        dec_legal     = 1'b1;
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm_type  = IMM_I;
      end
      OPC_STORE: begin
        dec_legal     = 1'b1;
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm_type  = IMM_S;
      end
      OPC_OP_IMM: begin
        if (funct3 == F3_ADD) begin
          dec_legal     = 1'b1;
          dec_reg_write = 1'b1;
          dec_alu_src   = 1'b1;
          dec_imm_type  = IMM_I;
        end
      end
      OPC_OP: begin
        if (funct3 == F3_ADD && (funct7 == F7_ADD || funct7 == F7_SUB)) begin
          dec_legal     = 1'b1;
          dec_reg_write = 1'b1;
          dec_alu_ctrl  = (funct7 == F7_SUB) ? ALU_SUB : ALU_ADD;
        end
      end
      OPC_LUI: begin
        dec_legal     = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_alu_ctrl  = ALU_PASS_B;
        dec_imm_type  = IMM_U;
      end
      OPC_SYSTEM: begin
        if (bus.in_instr == ECALL_WORD) begin
          dec_legal = 1'b1;
          dec_ecall = 1'b1;
        end
      end
`ifdef DECODE_BRANCH_EN
      OPC_BRANCH: begin
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          dec_legal    = 1'b1;
          dec_branch   = 1'b1;
          dec_alu_ctrl = ALU_SUB;
          dec_imm_type = IMM_B;
        end
      end
      OPC_JAL: begin
        dec_legal     = 1'b1;
        dec_reg_write = 1'b1;
        dec_jump      = 1'b1;
        dec_imm_type  = IMM_J;
      end
`endif
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Next state: ECALL drains its bundle before halting; illegal traps at once.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (accept && !dec_legal)     state_next = TRAP;
        else if (accept && dec_ecall) state_next = DRAIN;
      end
      DRAIN: begin
        if (bus.out_valid && bus.out_ready) state_next = HALTED;
      end
      default: ;
    endcase
  end

  // Output bundle, sticky flags and retired counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid     <= 1'b0;
      bus.out_rs1       <= '0;
      bus.out_rs2       <= '0;
      bus.out_rd        <= '0;
      bus.out_reg_write <= 1'b0;
      bus.out_mem_read  <= 1'b0;
      bus.out_mem_write <= 1'b0;
      bus.out_alu_src   <= 1'b0;
      bus.out_alu_ctrl  <= ALU_ADD;
      bus.out_imm       <= '0;
      bus.out_pc        <= '0;
`ifdef DECODE_BRANCH_EN
      bus.out_branch    <= 1'b0;
      bus.out_jump      <= 1'b0;
`endif
      finish            <= 1'b0;
      illegal           <= 1'b0;
      illegal_instr     <= '0;
      instr_count       <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      if (accept && dec_legal) begin
        bus.out_valid     <= 1'b1;
        bus.out_rs1       <= bus.in_instr[19:15];
        bus.out_rs2       <= bus.in_instr[24:20];
        bus.out_rd        <= bus.in_instr[11:7];
        bus.out_reg_write <= dec_reg_write && (bus.in_instr[11:7] != 5'd0);
        bus.out_mem_read  <= dec_mem_read;
        bus.out_mem_write <= dec_mem_write;
        bus.out_alu_src   <= dec_alu_src;
        bus.out_alu_ctrl  <= dec_alu_ctrl;
        bus.out_imm       <= dec_imm;
        bus.out_pc        <= bus.in_pc;
`ifdef DECODE_BRANCH_EN
        bus.out_branch    <= dec_branch;
        bus.out_jump      <= dec_jump;
`endif
        if (instr_count != '1) instr_count <= instr_count + CNT_W'(1);
      end
      if (accept && !dec_legal) begin
        illegal       <= 1'b1;
        illegal_instr <= bus.in_instr;
      end
      if (state == DRAIN && bus.out_valid && bus.out_ready) finish <= 1'b1;
    end
  end

endmodule
